// File: rtl/seq_arith_serial_addsub_if.sv
// Bit-serial add/sub stream bundle: LSB-first operand bits in, registered
// result bits and word-end flags out.
interface seq_arith_serial_addsub_if;
  logic in_val;
  logic in0;
  logic in1;
  logic sub;
  logic out_val;
  logic out;
  logic out_last;
  logic cout;
  logic ovf;

  modport master (
    output in_val, in0, in1, sub,
    input  out_val, out, out_last, cout, ovf
  );

  modport slave (
    input  in_val, in0, in1, sub,
    output out_val, out, out_last, cout, ovf
  );
endinterface

// File: rtl/seq_arith_serial_addsub.sv
// Parametrised bit-serial adder/subtractor, one bit pair per valid cycle,
// with per-word mode and registered last/carry/overflow flags.
module seq_arith_serial_addsub #(
  parameter int unsigned NBITS = 8
) (
  input logic                     clk,
  input logic                     reset,
  seq_arith_serial_addsub_if.slave bus
);

  localparam int unsigned CW = $clog2(NBITS);
  localparam logic [CW-1:0] LastCnt = CW'(NBITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          m_q, m_d;
  logic          out_q, out_d;
  logic          out_val_q, out_val_d;
  logic          out_last_q, out_last_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic       first, is_last, mode, cin, b;
  logic [1:0] sum;

  // Bit 0 takes mode and carry-in straight from sub so a word starts clean.
  always_comb begin
    first   = (cnt_q == '0);
    is_last = (cnt_q == LastCnt);
    mode    = first ? bus.sub : m_q;
    cin     = first ? bus.sub : c_q;
    b       = bus.in1 ^ mode;
    sum     = {1'b0, bus.in0} + {1'b0, b} + {1'b0, cin};
  end

  always_comb begin
    cnt_d      = cnt_q;
    c_d        = c_q;
    m_d        = m_q;
    out_d      = out_q;
    out_val_d  = 1'b0;
    out_last_d = 1'b0;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    if (bus.in_val) begin
      m_d        = mode;
      out_d      = sum[0];
      out_val_d  = 1'b1;
      out_last_d = is_last;
      if (is_last) begin
        cnt_d  = '0;
        c_d    = 1'b0;
        cout_d = sum[1];
        ovf_d  = cin ^ sum[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
        c_d   = sum[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      c_q        <= 1'b0;
      m_q        <= 1'b0;
      out_q      <= 1'b0;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      m_q        <= m_d;
      out_q      <= out_d;
      out_val_q  <= out_val_d;
      out_last_q <= out_last_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.out_val  = out_val_q;
  assign bus.out_last = out_last_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_seq_arith_serial_addsub.sv
// Scoreboard bench for seq_arith_serial_addsub: directed words push expected
// bits; a negedge monitor pops and compares every presented output bit.
module tb_seq_arith_serial_addsub;
  localparam int NBITS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  seq_arith_serial_addsub_if bus ();

  seq_arith_serial_addsub #(.NBITS(NBITS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic out;
    logic last;
    logic cout;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  logic rst_at_edge = 1'b1;
  logic prev_out = 1'b0;
  logic hold_c = 1'b0;
  logic hold_o = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rst_at_edge <= reset;

  // Monitor: every out_val pops one expected bit; flags must hold between words.
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      hold_c = 1'b0;
      hold_o = 1'b0;
    end
    if (bus.out_val === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_val: got out_val=1 want no output at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("out_bit", bus.out, e.out);
        chk("out_last", bus.out_last, e.last);
        if (e.last) begin
          hold_c = e.cout;
          hold_o = e.ovf;
        end
      end
    end else begin
      chk("out_last_idle", bus.out_last, 1'b0);
      if (!rst_at_edge) chk("out_hold", bus.out, prev_out);
    end
    chk("cout", bus.cout, hold_c);
    chk("ovf", bus.ovf, hold_o);
    prev_out = bus.out;
  end

  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [7:0] r, input logic co, input logic ov,
                           input int nb, input bit toggle, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) begin
        repeat ((i % 3) + 1) begin
          @(negedge clk);
          bus.in_val = 1'b0;
          bus.in0    = ~bus.in0;
          bus.in1    = 1'($urandom);
          bus.sub    = ~bus.sub;
        end
      end
      @(negedge clk);
      bus.in_val = 1'b1;
      bus.in0    = a[i];
      bus.in1    = b[i];
      bus.sub    = (i == 0) ? s : (toggle ? 1'(~s ^ i[0]) : s);
      sb.push_back('{out: r[i], last: (i == NBITS - 1), cout: co, ovf: ov});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_val = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_val"}, bus.out_val, 1'b0);
    chk({tag, "_out"}, bus.out, 1'b0);
    chk({tag, "_out_last"}, bus.out_last, 1'b0);
    chk({tag, "_cout"}, bus.cout, 1'b0);
    chk({tag, "_ovf"}, bus.ovf, 1'b0);
  endtask

  initial begin
    int waited;
    bus.in_val = 1'b0;
    bus.in0    = 1'b0;
    bus.in1    = 1'b0;
    bus.sub    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset");

    // 100+27
    send_word(8'd100, 8'd27, 1'b0, 8'h7F, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    idle(2);
    // 100+28 then 200+100 back-to-back
    send_word(8'd100, 8'd28, 1'b0, 8'h80, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    send_word(8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    idle(1);
    // 5-7 with sub toggling after bit 0, then 7-5
    send_word(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0, 8, 1'b1, 1'b0);
    send_word(8'd7, 8'd5, 1'b1, 8'h02, 1'b1, 1'b0, 8, 1'b1, 1'b0);
    // 0x80-0x01
    send_word(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8, 1'b0, 1'b0);

    // Abort after 3 bits; reset asserted together with a valid bit
    send_word(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    @(negedge clk);
    reset      = 1'b1;
    bus.in_val = 1'b1;
    bus.in0    = 1'b1;
    bus.in1    = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    bus.in_val = 1'b0;
    chk_all_zero("mid_reset");
    send_word(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    idle(1);

    // 0x0F+0x01 with stall gaps
    send_word(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 8, 1'b0, 1'b1);
    idle(1);

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    idle(2);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending outputs want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
